// File: rtl/control_unit_pkg.sv
// Shared CPU configuration: default widths, instruction field positions,
// ALU function, opcode and controller state encodings.
package cpuConfig;

  localparam int DEF_N      = 8;
  localparam int DEF_R_SIZE = 3;
  localparam int DEF_P_SIZE = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MULH  = 2'd2,
    ALU_PASSB = 2'd3
  } aluFunc_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_SUBI = 4'd4,
    OP_MULI = 4'd5,
    OP_LDI  = 4'd6,
    OP_JMP  = 4'd7,
    OP_BZ   = 4'd8,
    OP_WAIT = 4'd9,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } ctrlState_t;

  // Instruction layout: [opcode(4) | rd | rs | imm(n)], imm at bit 0.
  function automatic int rs_lsb(input int n);
    return n;
  endfunction

  function automatic int rd_lsb(input int n, input int r);
    return n + r;
  endfunction

  function automatic int opc_lsb(input int n, input int r);
    return n + 2 * r;
  endfunction

endpackage

// File: rtl/control_unit_button_sync.sv
// Push-button 2-flop synchronizer followed by a rising-edge detector.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/control_unit.sv
// Two-cycle fetch/execute sequencer with WAIT (button) and HALT states.
// Optional zero-flag conditional branch (BZ) enabled by CTRL_BRANCH_EN.
module control_unit
  import cpuConfig::*;
#(
  parameter int N      = DEF_N,
  parameter int R_SIZE = DEF_R_SIZE,
  parameter int P_SIZE = DEF_P_SIZE,
  parameter int I_W    = 4 + 2 * R_SIZE + N
) (
  input  logic              clk,
  input  logic              reset,
  output logic [P_SIZE-1:0] progAddr,
  input  logic [I_W-1:0]    progData,
  input  logic              button,
  input  logic [N-1:0]      aluResult,
  output logic              writeReg,
  output aluFunc_t          aluFunc,
  output logic              aluImmediate,
  output logic [R_SIZE-1:0] opD,
  output logic [R_SIZE-1:0] opS,
  output logic [N-1:0]      opT,
  output logic              halted
);

  localparam int RS_LSB  = rs_lsb(N);
  localparam int RD_LSB  = rd_lsb(N, R_SIZE);
  localparam int OPC_LSB = opc_lsb(N, R_SIZE);

  ctrlState_t        state, state_nx;
  logic [P_SIZE-1:0] pc, pc_nx;
  opcode_t           opc;
  logic [R_SIZE-1:0] rd, rs;
  logic [N-1:0]      imm;
  logic              rise;
  logic              zflag;

  assign opc = opcode_t'(progData[OPC_LSB +: 4]);
  assign rd  = progData[RD_LSB +: R_SIZE];
  assign rs  = progData[RS_LSB +: R_SIZE];
  assign imm = progData[N-1:0];

  button_sync u_button_sync (
    .clk   (clk),
    .reset (reset),
    .in    (button),
    .rise  (rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

`ifdef CTRL_BRANCH_EN
  // Flag tracks the result of the last register-writing instruction only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      zflag <= 1'b0;
    else if (state == EXEC && writeReg)
      zflag <= (aluResult == '0);
  end
`else
  logic unused_alu;
  assign zflag      = 1'b0;
  assign unused_alu = ^aluResult;
`endif

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    writeReg     = 1'b0;
    aluFunc      = ALU_ADD;
    aluImmediate = 1'b0;
    opD          = '0;
    opS          = '0;
    opT          = '0;
    case (state)
      FETCH: state_nx = EXEC;
      EXEC: begin
        opD      = rd;
        opS      = rs;
        opT      = imm;
        pc_nx    = pc + P_SIZE'(1);
        state_nx = FETCH;
        case (opc)
          OP_ADD:  writeReg = 1'b1;
          OP_SUB: begin
            writeReg = 1'b1;
            aluFunc  = ALU_SUB;
          end
          OP_ADDI: begin
            writeReg     = 1'b1;
            aluImmediate = 1'b1;
          end
          OP_SUBI: begin
            writeReg     = 1'b1;
            aluImmediate = 1'b1;
            aluFunc      = ALU_SUB;
          end
          OP_MULI: begin
            writeReg     = 1'b1;
            aluImmediate = 1'b1;
            aluFunc      = ALU_MULH;
          end
          OP_LDI: begin
            writeReg     = 1'b1;
            aluImmediate = 1'b1;
            aluFunc      = ALU_PASSB;
          end
          OP_JMP: pc_nx = imm[P_SIZE-1:0];
          OP_BZ: begin
            if (zflag)
              pc_nx = imm[P_SIZE-1:0];
          end
          // pc holds here; it advances on the button edge that leaves WAIT.
          OP_WAIT: begin
            pc_nx    = pc;
            state_nx = WAIT;
          end
          OP_HALT: begin
            pc_nx    = pc;
            state_nx = HALT;
          end
          default: ;
        endcase
      end
      WAIT: begin
        if (rise) begin
          pc_nx    = pc + P_SIZE'(1);
          state_nx = FETCH;
        end
      end
      HALT: ;
      default: state_nx = FETCH;
    endcase
  end

  assign progAddr = pc;
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: ROM + register-file/ALU model,
// table-driven single-instruction decode plus multi-cycle sequences.
module tb_control_unit;
  import cpuConfig::*;

  logic        clk;
  logic        reset;
  logic [4:0]  progAddr;
  logic [17:0] progData;
  logic        button;
  logic [7:0]  aluResult;
  logic        writeReg;
  aluFunc_t    aluFunc;
  logic        aluImmediate;
  logic [2:0]  opD, opS;
  logic [7:0]  opT;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  control_unit #(.N(8), .R_SIZE(3), .P_SIZE(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .progAddr     (progAddr),
    .progData     (progData),
    .button       (button),
    .aluResult    (aluResult),
    .writeReg     (writeReg),
    .aluFunc      (aluFunc),
    .aluImmediate (aluImmediate),
    .opD          (opD),
    .opS          (opS),
    .opT          (opT),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM
  logic [17:0] rom [32];
  always @(posedge clk) progData <= rom[progAddr];

  // Datapath model: register file and ALU
  logic [7:0]  regs [8];
  logic [7:0]  alu_a, alu_b;
  logic [15:0] prod;
  always_comb begin
    alu_a = regs[opD];
    alu_b = aluImmediate ? opT : regs[opS];
    prod  = alu_a * alu_b;
    case (aluFunc)
      ALU_ADD:  aluResult = alu_a + alu_b;
      ALU_SUB:  aluResult = alu_a - alu_b;
      ALU_MULH: aluResult = prod[15:8];
      default:  aluResult = alu_b;
    endcase
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else if (writeReg) begin
      regs[opD] <= aluResult;
    end
  end

  function automatic logic [17:0] ins(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s, input logic [7:0] t);
    return {op, d, s, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rom_clear;
    for (int i = 0; i < 32; i++) rom[i] = 18'd0;
  endtask

  task automatic do_reset(input logic check_outputs);
    @(negedge clk);
    reset  = 1'b1;
    button = 1'b0;
    tick();
    tick();
    if (check_outputs) begin
      chk("rst_writeReg", writeReg, 1'b0);
      chk("rst_aluFunc", aluFunc, ALU_ADD);
      chk("rst_aluImm", aluImmediate, 1'b0);
      chk("rst_ops", {opD, opS, opT}, 14'd0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_progAddr", progAddr, 5'd0);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [17:0] instr;
    logic        wr;
    aluFunc_t    func;
    logic        imm;
    logic [2:0]  d;
    logic [2:0]  s;
    logic [7:0]  t;
    logic        chk_ops;
    logic [4:0]  next_pc;
    logic        halt;
  } vec_t;

  vec_t vt [12];
  vec_t sb [$];
  vec_t e;
  int   bad;
  int   n;

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    rom_clear();

    vt[0]  = '{ins(4'd6, 3'd1, 3'd0, 8'd5),    1'b1, ALU_PASSB, 1'b1, 3'd1, 3'd0, 8'd5,   1'b1, 5'd1,  1'b0};
    vt[1]  = '{ins(4'd1, 3'd2, 3'd3, 8'd0),    1'b1, ALU_ADD,   1'b0, 3'd2, 3'd3, 8'd0,   1'b1, 5'd1,  1'b0};
    vt[2]  = '{ins(4'd2, 3'd7, 3'd1, 8'hAA),   1'b1, ALU_SUB,   1'b0, 3'd7, 3'd1, 8'hAA,  1'b1, 5'd1,  1'b0};
    vt[3]  = '{ins(4'd3, 3'd4, 3'd0, 8'h10),   1'b1, ALU_ADD,   1'b1, 3'd4, 3'd0, 8'h10,  1'b1, 5'd1,  1'b0};
    vt[4]  = '{ins(4'd4, 3'd5, 3'd6, 8'hFF),   1'b1, ALU_SUB,   1'b1, 3'd5, 3'd6, 8'hFF,  1'b1, 5'd1,  1'b0};
    vt[5]  = '{ins(4'd5, 3'd6, 3'd2, 8'd3),    1'b1, ALU_MULH,  1'b1, 3'd6, 3'd2, 8'd3,   1'b1, 5'd1,  1'b0};
    vt[6]  = '{ins(4'd0, 3'd3, 3'd4, 8'd9),    1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd1,  1'b0};
    vt[7]  = '{ins(4'd7, 3'd0, 3'd0, 8'd20),   1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd20, 1'b0};
    vt[8]  = '{ins(4'd12, 3'd1, 3'd1, 8'd7),   1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd1,  1'b0};
    vt[9]  = '{ins(4'd15, 3'd0, 3'd0, 8'd0),   1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd0,  1'b1};
    vt[10] = '{ins(4'd9, 3'd0, 3'd0, 8'd0),    1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd0,  1'b0};
    vt[11] = '{ins(4'd8, 3'd0, 3'd0, 8'd10),   1'b0, ALU_ADD,   1'b0, 3'd0, 3'd0, 8'd0,   1'b0, 5'd1,  1'b0};

    // Single-instruction decode table
    for (int i = 0; i < 12; i++) begin
      rom_clear();
      rom[0] = vt[i].instr;
      do_reset(i == 0);
      sb.push_back(vt[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_writeReg", i), writeReg, e.wr);
      chk($sformatf("v%0d_aluImm", i), aluImmediate, e.imm);
      if (e.chk_ops) begin
        chk($sformatf("v%0d_aluFunc", i), aluFunc, e.func);
        chk($sformatf("v%0d_opD", i), opD, e.d);
        chk($sformatf("v%0d_opS", i), opS, e.s);
        chk($sformatf("v%0d_opT", i), opT, e.t);
      end
      tick();
      chk($sformatf("v%0d_nextAddr", i), progAddr, e.next_pc);
      chk($sformatf("v%0d_halted", i), halted, e.halt);
      chk($sformatf("v%0d_wr_after", i), writeReg, 1'b0);
    end

    // LDI r2,#3; ADD r2,r2; HALT
    rom_clear();
    rom[0] = ins(4'd6, 3'd2, 3'd0, 8'd3);
    rom[1] = ins(4'd1, 3'd2, 3'd2, 8'd0);
    rom[2] = ins(4'd15, 3'd0, 3'd0, 8'd0);
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("add_opD", opD, 3'd2);
    chk("add_opS", opS, 3'd2);
    chk("add_aluImm", aluImmediate, 1'b0);
    chk("add_writeReg", writeReg, 1'b1);
    chk("add_aluResult", aluResult, 8'd6);
    tick(); tick(); tick();
    chk("halt_halted", halted, 1'b1);
    bad = 0;
    repeat (100) begin
      tick();
      if (writeReg !== 1'b0 || halted !== 1'b1 || progAddr !== 5'd2) bad++;
    end
    chk("halt_hold_100", bad, 0);

    // WAIT entered with button held high, then a fresh press
    rom_clear();
    rom[0] = ins(4'd7, 3'd0, 3'd0, 8'd4);
    rom[4] = ins(4'd9, 3'd0, 3'd0, 8'd0);
    rom[5] = ins(4'd15, 3'd0, 3'd0, 8'd0);
    do_reset(1'b0);
    button = 1'b1;
    tick(); tick(); tick(); tick();
    bad = 0;
    repeat (10) begin
      tick();
      if (progAddr !== 5'd4 || writeReg !== 1'b0 || halted !== 1'b0) bad++;
    end
    chk("wait_held_button", bad, 0);
    button = 1'b0;
    repeat (3) tick();
    chk("wait_still_addr", progAddr, 5'd4);
    button = 1'b1;
    n = 0;
    while (progAddr !== 5'd5 && n < 10) begin
      tick();
      n++;
    end
    chk("wait_exit_latency", n, 3);
    chk("wait_exit_addr", progAddr, 5'd5);
    tick(); tick();
    chk("wait_then_halt", halted, 1'b1);

    // pc wrap 31 -> 0
    rom_clear();
    rom[0]  = ins(4'd7, 3'd0, 3'd0, 8'd31);
    rom[31] = ins(4'd0, 3'd0, 3'd0, 8'd0);
    do_reset(1'b0);
    tick(); tick();
    chk("jmp31_addr", progAddr, 5'd31);
    tick(); tick();
    chk("wrap_addr", progAddr, 5'd0);

    // Zero-flag branch taken (r1=5, SUBI #5)
    rom_clear();
    rom[0] = ins(4'd6, 3'd1, 3'd0, 8'd5);
    rom[1] = ins(4'd4, 3'd1, 3'd0, 8'd5);
    rom[2] = ins(4'd8, 3'd0, 3'd0, 8'd10);
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("subi5_aluResult", aluResult, 8'd0);
    tick(); tick(); tick();
`ifdef CTRL_BRANCH_EN
    chk("bz_zero_addr", progAddr, 5'd10);
`else
    chk("bz_zero_addr", progAddr, 5'd3);
`endif

    // Zero-flag branch not taken (r1=6)
    rom[0] = ins(4'd6, 3'd1, 3'd0, 8'd6);
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("subi6_aluResult", aluResult, 8'd1);
    tick(); tick(); tick();
    chk("bz_nonzero_addr", progAddr, 5'd3);

    // Reset during EXEC of ADDI
    rom_clear();
    rom[0] = ins(4'd3, 3'd1, 3'd0, 8'd1);
    do_reset(1'b0);
    tick();
    chk("mid_exec_wr_before", writeReg, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_exec_wr_drop", writeReg, 1'b0);
    chk("mid_exec_addr", progAddr, 5'd0);
    @(negedge clk);
    chk("mid_exec_reg_kept", regs[1], 8'd0);
    reset = 1'b0;
    tick();
    chk("mid_exec_restart_wr", writeReg, 1'b1);

    // Reset during WAIT
    rom_clear();
    rom[0] = ins(4'd7, 3'd0, 3'd0, 8'd4);
    rom[4] = ins(4'd9, 3'd0, 3'd0, 8'd0);
    do_reset(1'b0);
    repeat (5) tick();
    chk("mid_wait_addr_before", progAddr, 5'd4);
    #2 reset = 1'b1;
    #1;
    chk("mid_wait_addr_reset", progAddr, 5'd0);
    chk("mid_wait_halted", halted, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("mid_wait_refetch", progAddr, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
